// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and default widths for the MEM/WB segment register.
//   mw_state_e : memory-access FSM state (IDLE, WAIT)
//   req_buf_t  : request buffer that holds a missed access while it is outstanding
//   *_DEF      : default datapath widths; the top-level parameters start from these
package mem_wb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RADDR_W_DEF = 5;
  localparam int RW_W_DEF    = 3;
  localparam int WE_W_DEF    = XLEN_DEF / 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mw_state_e;

  // The buffer is sized from the package defaults. If the core is built with a
  // different XLEN, change XLEN_DEF here as well.
  typedef struct packed {
    logic [XLEN_DEF-1:0] addr;
    logic [XLEN_DEF-1:0] wdata;
    logic [WE_W_DEF-1:0] we;
    logic                rd;
  } req_buf_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter used for cache hit/miss statistics.
//   clk, rst : clock, asynchronous active-high reset
//   inc_i    : count one event this cycle
//   clr_i    : synchronous clear; takes priority over inc_i
//   cnt_o    : current count; sticks at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && ~&cnt_q)    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_wb_seg_reg.sv
// mem_wb_seg_reg: MEM/WB segment register with a variable-latency data-memory port.
//   Segment inputs  : *_e from the E stage, gated by en / clear from the hazard unit
//   Segment outputs : *_mw registered copies, rd_data registered load data
//   Memory request  : mem_req / mem_we / mem_addr / mem_wdata (word-aligned address)
//   Memory response : mem_rvalid / mem_rdata (completes both reads and writes)
//   mem_stall       : high while an access is waiting on the memory
//   Statistics      : hit_cnt / miss_cnt, cleared by cnt_clr
// Build option MWSEG_PERF_CNT_EN: when defined, the saturating hit/miss counters
// are built; otherwise hit_cnt/miss_cnt read 0 and cnt_clr is ignored.
module mem_wb_seg_reg
  import mem_wb_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int RADDR_W = RADDR_W_DEF,
  parameter int RW_W    = RW_W_DEF,
  parameter int CNT_W   = 32,
  parameter int WE_W    = XLEN / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic [XLEN-1:0]    alu_out_e,
  input  logic [XLEN-1:0]    store_data_e,
  input  logic [XLEN-1:0]    pc_e,
  input  logic [RADDR_W-1:0] rd_e,
  input  logic [WE_W-1:0]    mem_write_e,
  input  logic [RW_W-1:0]    reg_write_e,
  input  logic               mem_to_reg_e,
  input  logic               load_npc_e,
  output logic [XLEN-1:0]    alu_out_mw,
  output logic [XLEN-1:0]    pc_mw,
  output logic [RADDR_W-1:0] rd_mw,
  output logic [RW_W-1:0]    reg_write_mw,
  output logic               mem_to_reg_mw,
  output logic               load_npc_mw,
  output logic [XLEN-1:0]    rd_data,
  output logic               mem_req,
  output logic [WE_W-1:0]    mem_we,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_wdata,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  output logic               mem_stall,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  mw_state_e state_q, state_d;
  req_buf_t  buf_q, buf_d;

  logic access, hit, miss, rd_done;

  logic [XLEN-1:0]    alu_q, pc_q, rdat_q;
  logic [RADDR_W-1:0] rd_q;
  logic [RW_W-1:0]    rw_q;
  logic               m2r_q, npc_q;

  // A flushed instruction is never an access, so a cleared store cannot write.
  assign access = (mem_to_reg_e | (|mem_write_e)) & ~clear;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    mem_req   = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_stall = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;
    rd_done   = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req   = access;
        mem_addr  = {alu_out_e[XLEN-1:2], 2'b00};
        mem_wdata = store_data_e;
        mem_we    = mem_write_e;
        if (access) begin
          if (mem_rvalid) begin
            hit     = 1'b1;
            rd_done = mem_to_reg_e;
          end else begin
            miss       = 1'b1;
            mem_stall  = 1'b1;
            state_d    = WAIT;
            buf_d.addr  = {alu_out_e[XLEN-1:2], 2'b00};
            buf_d.wdata = store_data_e;
            buf_d.we    = mem_write_e;
            buf_d.rd    = mem_to_reg_e;
          end
        end
      end
      WAIT: begin
        // E inputs may change while stalled; the request comes from the buffer.
        mem_req   = 1'b1;
        mem_addr  = buf_q.addr;
        mem_wdata = buf_q.wdata;
        mem_we    = buf_q.we;
        if (mem_rvalid) begin
          state_d = IDLE;
          rd_done = buf_q.rd;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Keep the request channel quiet while reset is held, whatever E presents.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q  <= '0;
      pc_q   <= '0;
      rd_q   <= '0;
      rw_q   <= '0;
      m2r_q  <= 1'b0;
      npc_q  <= 1'b0;
      rdat_q <= '0;
    end else if (en) begin
      if (clear) begin
        alu_q  <= '0;
        pc_q   <= '0;
        rd_q   <= '0;
        rw_q   <= '0;
        m2r_q  <= 1'b0;
        npc_q  <= 1'b0;
        rdat_q <= '0;   // also drops read data of a flushed in-flight load
      end else begin
        alu_q  <= alu_out_e;
        pc_q   <= pc_e;
        rd_q   <= rd_e;
        rw_q   <= reg_write_e;
        m2r_q  <= mem_to_reg_e;
        npc_q  <= load_npc_e;
        rdat_q <= rd_done ? mem_rdata : '0;
      end
    end
  end

  assign alu_out_mw    = alu_q;
  assign pc_mw         = pc_q;
  assign rd_mw         = rd_q;
  assign reg_write_mw  = rw_q;
  assign mem_to_reg_mw = m2r_q;
  assign load_npc_mw   = npc_q;
  assign rd_data       = rdat_q;

`ifdef MWSEG_PERF_CNT_EN
  // Misses count on the IDLE->WAIT edge, so a long miss is counted once.
  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk(clk), .rst(rst), .inc_i(hit), .clr_i(cnt_clr), .cnt_o(hit_cnt)
  );
  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk(clk), .rst(rst), .inc_i(miss), .clr_i(cnt_clr), .cnt_o(miss_cnt)
  );
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_clr, hit, miss};
  assign hit_cnt    = '0;
  assign miss_cnt   = '0;
`endif

endmodule

// File: tb/tb_mem_wb_seg_reg.sv
module tb_mem_wb_seg_reg;

  localparam int XLEN = 32, RADDR_W = 5, RW_W = 3, CNT_W = 4, WE_W = 4;
`ifdef MWSEG_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en, clear, mem_to_reg_e, load_npc_e, mem_rvalid, cnt_clr;
  logic [XLEN-1:0] alu_out_e, store_data_e, pc_e, mem_rdata;
  logic [RADDR_W-1:0] rd_e;
  logic [WE_W-1:0] mem_write_e;
  logic [RW_W-1:0] reg_write_e;

  logic [XLEN-1:0] alu_out_mw, pc_mw, rd_data, mem_addr, mem_wdata;
  logic [RADDR_W-1:0] rd_mw;
  logic [RW_W-1:0] reg_write_mw;
  logic mem_to_reg_mw, load_npc_mw, mem_req, mem_stall;
  logic [WE_W-1:0] mem_we;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int tests = 0, fails = 0;

  mem_wb_seg_reg #(.XLEN(XLEN), .RADDR_W(RADDR_W), .RW_W(RW_W), .CNT_W(CNT_W), .WE_W(WE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear),
    .alu_out_e(alu_out_e), .store_data_e(store_data_e), .pc_e(pc_e), .rd_e(rd_e),
    .mem_write_e(mem_write_e), .reg_write_e(reg_write_e),
    .mem_to_reg_e(mem_to_reg_e), .load_npc_e(load_npc_e),
    .alu_out_mw(alu_out_mw), .pc_mw(pc_mw), .rd_mw(rd_mw), .reg_write_mw(reg_write_mw),
    .mem_to_reg_mw(mem_to_reg_mw), .load_npc_mw(load_npc_mw), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: one access may be outstanding; it is either answered in
  // its issue cycle (hit) or waits until the memory answers (miss).
  bit        m_busy = 0, m_rd = 0, m_acc = 0, m_done = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_alu = 0, m_pc = 0, m_rdd = 0;
  logic [3:0]  m_we = 0;
  logic [4:0]  m_rdi = 0;
  logic [2:0]  m_rw = 0;
  bit          m_m2r = 0, m_npc = 0;
  int          m_hits = 0, m_miss = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_rd = 0; m_addr = 0; m_wdata = 0; m_we = 0;
      m_alu = 0; m_pc = 0; m_rdd = 0; m_rdi = 0; m_rw = 0; m_m2r = 0; m_npc = 0;
      m_hits = 0; m_miss = 0;
    end else begin
      m_acc  = (mem_to_reg_e || mem_write_e != 0) && !clear;
      m_done = mem_rvalid && (m_busy ? m_rd : (m_acc && mem_to_reg_e));
      if (en) begin
        if (clear) begin
          m_alu = 0; m_pc = 0; m_rdi = 0; m_rw = 0; m_m2r = 0; m_npc = 0; m_rdd = 0;
        end else begin
          m_alu = alu_out_e; m_pc = pc_e; m_rdi = rd_e; m_rw = reg_write_e;
          m_m2r = mem_to_reg_e; m_npc = load_npc_e;
          m_rdd = m_done ? mem_rdata : 32'h0;
        end
      end
      if (cnt_clr) begin
        m_hits = 0; m_miss = 0;
      end
      if (m_busy) begin
        if (mem_rvalid) m_busy = 0;
      end else if (m_acc) begin
        if (mem_rvalid) begin
          if (!cnt_clr && m_hits < CMAX) m_hits++;
        end else begin
          m_busy = 1; m_rd = mem_to_reg_e; m_we = mem_write_e;
          m_addr = alu_out_e & 32'hFFFF_FFFC; m_wdata = store_data_e;
          if (!cnt_clr && m_miss < CMAX) m_miss++;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    bit e_req, e_stall, acc;
    logic [31:0] e_addr, e_wdata;
    logic [3:0] e_we;
    acc = (mem_to_reg_e || mem_write_e != 0) && !clear;
    if (rst) begin
      e_req = 0; e_stall = 0; e_addr = 0; e_wdata = 0; e_we = 0;
    end else if (m_busy) begin
      e_req = 1; e_stall = !mem_rvalid; e_addr = m_addr; e_wdata = m_wdata; e_we = m_we;
    end else begin
      e_req = acc; e_stall = acc && !mem_rvalid;
      e_addr = alu_out_e & 32'hFFFF_FFFC; e_wdata = store_data_e; e_we = mem_write_e;
    end
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_stall", 32'(mem_stall), 32'(e_stall));
    if (e_req) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("mem_we", 32'(mem_we), 32'(e_we));
    end
    chk("alu_out_mw", alu_out_mw, m_alu);
    chk("pc_mw", pc_mw, m_pc);
    chk("rd_mw", 32'(rd_mw), 32'(m_rdi));
    chk("reg_write_mw", 32'(reg_write_mw), 32'(m_rw));
    chk("mem_to_reg_mw", 32'(mem_to_reg_mw), 32'(m_m2r));
    chk("load_npc_mw", 32'(load_npc_mw), 32'(m_npc));
    chk("rd_data", rd_data, m_rdd);
    chk("hit_cnt", 32'(hit_cnt), PERF ? 32'(m_hits) : 32'h0);
    chk("miss_cnt", 32'(miss_cnt), PERF ? 32'(m_miss) : 32'h0);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    en = 1; clear = 0; mem_to_reg_e = 0; load_npc_e = 0; mem_rvalid = 0; cnt_clr = 0;
    alu_out_e = 0; store_data_e = 0; pc_e = 0; mem_rdata = 0; rd_e = 0;
    mem_write_e = 0; reg_write_e = 0;
  endtask

  task automatic load_e(input logic [31:0] a, input logic [31:0] pc, input logic [4:0] rd);
    alu_out_e = a; pc_e = pc; rd_e = rd; reg_write_e = 3'b001;
    mem_to_reg_e = 1; mem_write_e = 0;
  endtask

  initial begin
    int stalls;
    bit req_seen;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 32'h0);
    chk("reset_alu_out_mw", alu_out_mw, 32'h0);

    // Reset mid-WAIT
    load_e(32'h0000_0040, 32'h3C, 5'd7);
    #1 chk("rst_gates_req", 32'(mem_req), 32'h0);
    rst = 0; en = 0;
    @(negedge clk); chk("rstw_first_stall", 32'(mem_stall), 32'h1);
    cyc();
    @(negedge clk); chk("rstw_wait_addr", mem_addr, 32'h0000_0040);
    #2 rst = 1; mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    #1 chk("rstw_req_low", 32'(mem_req), 32'h0);
    chk("rstw_rd_data", rd_data, 32'h0);
    cyc();
    rst = 0; set_idle(); mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk); chk("stray_rvalid_stall", 32'(mem_stall), 32'h0);
    cyc();
    chk("no_stale_rd_data", rd_data, 32'h0);

    // Hit
    set_idle(); load_e(32'h0000_0104, 32'h100, 5'd5); load_npc_e = 1;
    mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("hit_no_stall", 32'(mem_stall), 32'h0);
    cyc();
    chk("hit_rd_data", rd_data, 32'hDEAD_BEEF);
    chk("hit_rd_mw", 32'(rd_mw), 32'd5);
    chk("hit_cnt_1", 32'(hit_cnt), PERF ? 32'd1 : 32'd0);

    // Miss, latency 3
    set_idle(); load_e(32'h0000_0203, 32'h200, 5'd9); en = 0; stalls = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      chk("miss_addr_held", mem_addr, 32'h0000_0200);
      cyc();
      alu_out_e = 32'hA5A5_0000 + 32'(i); store_data_e = 32'h7777_0000 + 32'(i);
    end
    alu_out_e = 32'h0000_0203; store_data_e = 0;
    en = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    if (mem_stall) stalls++;
    cyc();
    chk("miss_stall_cycles", 32'(stalls), 32'd3);
    chk("miss_rd_data", rd_data, 32'h1234_5678);
    chk("miss_alu_out_mw", alu_out_mw, 32'h0000_0203);
    chk("miss_cnt_1", 32'(miss_cnt), PERF ? 32'd1 : 32'd0);

    // Flushed store
    set_idle(); alu_out_e = 32'h300; store_data_e = 32'hCAFE_F00D; mem_write_e = 4'b0011;
    pc_e = 32'h300; rd_e = 5'd3; clear = 1;
    req_seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (mem_req) req_seen = 1;
      cyc();
    end
    chk("flush_store_no_req", 32'(req_seen), 32'h0);
    chk("flush_alu_out_mw", alu_out_mw, 32'h0);
    chk("flush_pc_mw", pc_mw, 32'h0);
    chk("flush_rd_mw", 32'(rd_mw), 32'h0);

    // Clear during WAIT
    set_idle(); load_e(32'h0000_0080, 32'h80, 5'd11); en = 0;
    cyc();
    clear = 1;
    @(negedge clk); chk("wclr_req_kept", 32'(mem_req), 32'h1);
    cyc();
    en = 1; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk); chk("wclr_done_stall", 32'(mem_stall), 32'h0);
    cyc();
    chk("wclr_rd_data", rd_data, 32'h0);
    chk("wclr_alu_out_mw", alu_out_mw, 32'h0);
    set_idle();
    @(negedge clk); chk("wclr_back_idle", 32'(mem_req), 32'h0);
    cyc();

    // Store miss, latency 1
    set_idle(); alu_out_e = 32'h0000_0406; store_data_e = 32'h0BAD_CAFE;
    mem_write_e = 4'b1111; pc_e = 32'h404; en = 0;
    cyc();
    en = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk); chk("st_wait_we", 32'(mem_we), 32'hF);
    cyc();
    chk("st_rd_data", rd_data, 32'h0);

    // Saturation and counter clear
    set_idle();
    for (int i = 0; i < 20; i++) begin
      load_e(32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i), 5'(i));
      load_npc_e = i[0];
      mem_rvalid = 1; mem_rdata = 32'h1000_0000 + 32'(i);
      cyc();
    end
    chk("sat_rd_data", rd_data, 32'h1000_0013);
    chk("hit_cnt_sat", 32'(hit_cnt), PERF ? 32'd15 : 32'd0);
    cnt_clr = 1;
    cyc();
    cnt_clr = 0;
    chk("hit_cnt_clr_prio", 32'(hit_cnt), 32'd0);
    chk("miss_cnt_clr", 32'(miss_cnt), 32'd0);
    cyc();
    chk("hit_cnt_after_clr", 32'(hit_cnt), PERF ? 32'd1 : 32'd0);

    set_idle();
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_seg_reg.md
# mem_wb_seg_reg

Parametrised memory/write-back segment register for the pipelined RISC-V core. It latches the E-stage ALU result, destination register, PC and write-back controls. It issues the data-memory access over a request/response handshake that tolerates variable latency (cache hit or miss), stalls the pipeline while a miss is outstanding, and holds load data across stalls. Optional saturating hit/miss counters support cache evaluation.

## Interface
Parameters:
- XLEN, 32, datapath and address width
- RADDR_W, 5, register index width
- RW_W, 3, RegWrite code width
- CNT_W, 32, performance counter width
- WE_W, XLEN/8, byte-enable width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  segment enable from hazard unit
- clear  in  1  segment flush
- alu_out_e / store_data_e / pc_e  in  XLEN  E-stage result (memory address) / store data / PC
- rd_e  in  RADDR_W  destination register
- mem_write_e  in  WE_W  store byte enables; any bit set marks a store
- reg_write_e  in  RW_W  write-back code
- mem_to_reg_e, load_npc_e  in  1  load marker; PC+4 write-back select
- alu_out_mw, pc_mw  out  XLEN  registered copies
- rd_mw  out  RADDR_W; reg_write_mw  out  RW_W; mem_to_reg_mw, load_npc_mw  out  1
- rd_data  out  XLEN  registered load data
- mem_req  out  1; mem_we  out  WE_W; mem_addr, mem_wdata  out  XLEN  request channel
- mem_rvalid  in  1; mem_rdata  in  XLEN  completion channel (reads and writes)
- mem_stall  out  1  stall request to hazard unit
- cnt_clr  in  1  synchronous counter clear
- hit_cnt, miss_cnt  out  CNT_W  access statistics

## Operation
- An access is (mem_to_reg_e | mem_write_e≠0) with clear low.
- FSM has two states: IDLE and WAIT.
- IDLE: mem_req = access, driven combinationally from E inputs. mem_addr is alu_out_e with low 2 bits zeroed. mem_we = mem_write_e.
  - mem_rvalid in the same cycle: hit. Stay IDLE, no stall.
  - Otherwise: miss. Capture addr/wdata/we/read-flag into a request buffer and go to WAIT.
- WAIT: mem_req=1, request fields driven from the buffer. On mem_rvalid go to IDLE.
- mem_stall = (IDLE & access & ~mem_rvalid) | (WAIT & ~mem_rvalid).
- Segment fields update only when en. They load 0 if clear, else their E inputs. They hold when en is low.
- rd_data updates when en:
  - clear → 0.
  - Completing read (mem_rvalid & read) → mem_rdata.
  - Otherwise → 0.
  - Holds while en is low.
- clear in WAIT does not abort the transaction. It completes and its read data is discarded, because clear zeroes rd_data.
- clear in IDLE suppresses mem_req, so a flushed store never writes.
- Counters:
  - +1 hit per hit; +1 miss per IDLE→WAIT transition. Each access is counted once, not per stalled cycle.
  - Both saturate at all-ones.
  - cnt_clr has priority over increment.

## Timing
- Reset: all outputs, counters, buffer = 0; state IDLE; mem_req low.
- Hit: zero extra cycles; rd_data is valid one edge after the access cycle.
- Miss with memory latency N cycles: mem_stall is high for N cycles. mem_stall is low in the mem_rvalid cycle, so the pipeline advances at that edge and rd_data loads mem_rdata.
- A reset asserted mid-WAIT returns the FSM to IDLE immediately. The memory is reset by the same signal.
- A mem_rvalid with no request outstanding is ignored.
- If en is low for a reason other than this block's stall, an IDLE hit still completes. The read data is lost unless en is high, so the hazard unit keeps en=1 whenever mem_stall=0 and a load is in E.

## Configuration
- Macro: MWSEG_PERF_CNT_EN.
- Defined: the counters are implemented as specified.
- Undefined: no counter logic is built; hit_cnt/miss_cnt are tied to 0 and cnt_clr is ignored. Ports remain for interface stability.

## Structure
- Package mem_wb_pkg holds:
  - state enum {IDLE, WAIT}
  - default width constants (XLEN, RADDR_W, RW_W)
  - the request-buffer struct (addr, wdata, we, rd)
- Sub-module sat_counter (CNT_W, inc, clr, async rst) is instantiated twice inside the macro guard.

## Test plan
- Reset mid-WAIT, load to 0x0000_0040 outstanding → state IDLE, mem_req=0, all outputs 0 while rst high; no stale rd_data after release.
- Load 0x0000_0104 with mem_rvalid same cycle, mem_rdata=0xDEAD_BEEF → no stall; rd_data=0xDEAD_BEEF next edge; hit_cnt=1.
- Load, memory latency 3 cycles, rdata=0x1234_5678:
  - mem_stall high 3 cycles;
  - mem_addr held from the buffer while E inputs are toggled;
  - rd_data=0x1234_5678 after release;
  - miss_cnt=1, not 3.
- Store 0xCAFE_F00D, mem_write_e=4'b0011, with clear=1 → mem_req never asserted; all MW fields 0.
- clear asserted in WAIT on a load → transaction completes; rd_data=0; alu_out_mw=0.
- Counters preset near all-ones (CNT_W=4) with 20 hits → hit_cnt=15 saturates. cnt_clr on the same cycle as a hit → hit_cnt=0.
